lzw_forward_sched: RTL
======================

Name: lzw_forward_sched

Overview:
- Controller that sequences the header and payload FIFOs of the LZW forward-prepare stage into one byte stream for the LZW compressor.
- Per packet: answers the head FIFO request, drains the header, then (unless the packet has no payload) answers the payload FIFO request and drains the payload.
- Output is a valid/ready byte stream with SOP/EOP/header markers.
- Also enforces a payload length limit, counts packets, and flags truncations.

Parameters:
- PLOAD_MAX_LEN, 2048: max payload bytes forwarded per packet; longer packets are truncated (range 1..65535).
- CNT_W, 16: width of the packet counter.

Ports:
- I_sys_clk  in  1  system clock, 250 MHz
- I_sys_rst  in  1  synchronous active-high reset
- I_enable  in  1  allow start of a new packet
- I_head_no_pload  in  1  current head-FIFO packet has no payload; valid while I_fifo_head_req=1
- I_fifo_head_req  in  1  head FIFO holds a complete header
- O_fifo_head_ack  out  1  one-cycle grant to head FIFO
- O_fifo_head_rd  out  1  pop head FIFO
- I_fifo_head_rdata  in  9  FWFT word; [7:0] byte, [8] last byte of header
- I_fifo_head_empty  in  1  head FIFO empty
- I_fifo_pload_req  in  1  payload FIFO holds a complete payload
- O_fifo_pload_ack  out  1  one-cycle grant to payload FIFO
- O_fifo_pload_rd  out  1  pop payload FIFO
- I_fifo_pload_rdata  in  9  FWFT word; [8] last payload byte
- I_fifo_pload_empty  in  1  payload FIFO empty
- O_lzw_data  out  8  output byte
- O_lzw_valid  out  1  output byte valid
- I_lzw_ready  in  1  downstream accepts
- O_lzw_sop  out  1  first byte of packet
- O_lzw_eop  out  1  last byte of packet
- O_lzw_hdr  out  1  byte belongs to header
- O_pkt_cnt  out  CNT_W  packets completed; wraps
- O_err_trunc  out  1  one-cycle pulse on truncation
- O_busy  out  1  state != IDLE or O_lzw_valid

Behaviour:
- Reset values:
  - All outputs are 0; O_pkt_cnt is 0.
  - State is IDLE; the output register is empty.
  - FIFO contents are not touched.
- FIFOs are first-word-fall-through. rdata is valid whenever !empty, and rd pops the current word.
- Output stage: one register with valid/ready.
  - Accept condition: load = !O_lzw_valid || I_lzw_ready.
  - rd is asserted only in read states, with !empty && load, so each popped word is loaded into the output register in the same cycle.
  - Throughput is 1 byte/clk.
- O_lzw_valid holds, with data stable, until I_lzw_ready.
- States:
  - IDLE: if I_enable && I_fifo_head_req, latch no_pload <= I_head_no_pload and go to H_ACK.
  - H_ACK: O_fifo_head_ack=1 for one cycle, then H_RD.
  - H_RD:
    - Pop header bytes with O_lzw_hdr=1; the first byte has sop=1.
    - When the popped word has [8]=1 and no_pload=1: eop=1, O_pkt_cnt++, go to IDLE.
    - When the popped word has [8]=1 and no_pload=0: go to P_WAIT.
  - P_WAIT: wait for I_fifo_pload_req, then P_ACK (no timeout).
  - P_ACK: O_fifo_pload_ack=1 for one cycle, then P_RD; clear len counter.
  - P_RD:
    - Pop payload bytes with hdr=0, len++.
    - A word with [8]=1 gets eop=1, O_pkt_cnt++, go to IDLE.
    - If len reaches PLOAD_MAX_LEN on a word with [8]=0: that byte gets eop=1, O_err_trunc pulses, O_pkt_cnt++, go to FLUSH.
  - FLUSH:
    - O_fifo_pload_rd = !empty, independent of ready; popped bytes are discarded.
    - Go to IDLE after popping a word with [8]=1.
- Boundary conditions:
  - Length exactly PLOAD_MAX_LEN with [8]=1 on the last byte: normal EOP, no error.
  - A one-byte header with no_pload: that byte carries sop=1, eop=1, hdr=1.
  - A FIFO going empty mid-packet stalls the read without creating bubbles in the state; output valid simply drops.
  - I_enable deasserted mid-packet: the current packet completes; only new starts are blocked.
  - A new packet may start in the cycle after IDLE is re-entered; the output register may still hold the previous EOP.
  - I_sys_rst mid-packet: immediate return to reset values; a partial packet is lost.
- Ack and rd are never asserted together. The head and payload FIFOs are never read in the same cycle.

Decomposition:
- Shared package lzw_fwd_pkg:
  - state encoding: IDLE, H_ACK, H_RD, P_WAIT, P_ACK, P_RD, FLUSH
  - FIFO word width 9; LAST bit index 8
  - default PLOAD_MAX_LEN
- One sub-module, lzw_fwd_out_reg: the single-entry valid/ready output register carrying {data, sop, eop, hdr}.

Test Plan:
- Header 4 bytes (0x11..0x14, last flagged) plus payload 3 bytes (0xA0..0xA2), ready=1 -> head ack pulse, then 4 header bytes (hdr=1, sop on 0x11), then pload ack pulse, then 3 payload bytes (eop on 0xA2); O_pkt_cnt=1.
- no_pload=1, 2-byte header -> no pload ack; eop on the 2nd header byte; returns to IDLE; payload FIFO untouched.
- PLOAD_MAX_LEN=8, 12-byte payload -> 8 bytes out with eop on the 8th; O_err_trunc one pulse; 4 bytes flushed; the next packet starts clean.
- Random ready deassertion (50%) over a 64-byte payload -> byte order and count preserved; data stable while valid && !ready; no pop while the output is held.
- Reset asserted mid-P_RD -> next cycle all outputs 0, state IDLE; after reset, a new head_req is granted normally.
- I_enable=0 with head_req=1 -> no ack; enable dropped mid-packet -> the packet completes and the next one is blocked.

Source files
------------

// File: rtl/lzw_fwd_pkg.sv
// Shared types and constants for the LZW forward-prepare scheduler.
package lzw_fwd_pkg;

    localparam int FIFO_W            = 9;
    localparam int LAST_BIT          = 8;
    localparam int DEF_PLOAD_MAX_LEN = 2048;
    // One bit wider than the largest legal length so len+1 never wraps.
    localparam int LEN_W             = 17;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        H_ACK  = 3'd1,
        H_RD   = 3'd2,
        P_WAIT = 3'd3,
        P_ACK  = 3'd4,
        P_RD   = 3'd5,
        FLUSH  = 3'd6
    } state_t;

    // One byte of the outgoing stream together with its framing markers.
    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       hdr;
    } out_beat_t;

endpackage

// File: rtl/lzw_forward_sched_if.sv
// Byte stream from the scheduler to the LZW compressor.
interface lzw_forward_sched_if;

    logic [7:0] lzw_data;
    logic       lzw_valid;
    logic       lzw_ready;
    logic       lzw_sop;
    logic       lzw_eop;
    logic       lzw_hdr;

    modport master (
        output lzw_data,
        output lzw_valid,
        output lzw_sop,
        output lzw_eop,
        output lzw_hdr,
        input  lzw_ready
    );

    modport slave (
        input  lzw_data,
        input  lzw_valid,
        input  lzw_sop,
        input  lzw_eop,
        input  lzw_hdr,
        output lzw_ready
    );

endinterface

// File: rtl/lzw_fwd_out_reg.sv
// Single-entry valid/ready output register for the scheduler byte stream.
module lzw_fwd_out_reg
    import lzw_fwd_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  out_beat_t                  i_beat,
    output logic                       o_load,
    lzw_forward_sched_if.master        lzw
);

    logic      r_valid;
    out_beat_t r_beat;

    // The slot can take a new beat when it is empty or being drained this cycle.
    assign o_load = !r_valid || lzw.lzw_ready;

    // Hold the beat stable until the consumer accepts it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_beat  <= '0;
        end else if (o_load) begin
            r_valid <= i_push;
            if (i_push) begin
                r_beat <= i_beat;
            end
        end
    end

    assign lzw.lzw_valid = r_valid;
    assign lzw.lzw_data  = r_beat.data;
    assign lzw.lzw_sop   = r_beat.sop;
    assign lzw.lzw_eop   = r_beat.eop;
    assign lzw.lzw_hdr   = r_beat.hdr;

endmodule

// File: rtl/lzw_forward_sched.sv
// Sequences header and payload FIFOs into one framed byte stream for LZW,
// enforcing a payload length limit and counting completed packets.
module lzw_forward_sched
    import lzw_fwd_pkg::*;
#(
    parameter int PLOAD_MAX_LEN = DEF_PLOAD_MAX_LEN,
    parameter int CNT_W         = 16
)(
    input  logic                 I_sys_clk,
    input  logic                 I_sys_rst,
    input  logic                 I_enable,
    input  logic                 I_head_no_pload,
    input  logic                 I_fifo_head_req,
    output logic                 O_fifo_head_ack,
    output logic                 O_fifo_head_rd,
    input  logic [FIFO_W-1:0]    I_fifo_head_rdata,
    input  logic                 I_fifo_head_empty,
    input  logic                 I_fifo_pload_req,
    output logic                 O_fifo_pload_ack,
    output logic                 O_fifo_pload_rd,
    input  logic [FIFO_W-1:0]    I_fifo_pload_rdata,
    input  logic                 I_fifo_pload_empty,
    lzw_forward_sched_if.master  lzw,
    output logic [CNT_W-1:0]     O_pkt_cnt,
    output logic                 O_err_trunc,
    output logic                 O_busy
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PLOAD_MAX_LEN);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_no_pload;
    logic               w_no_pload_next;
    logic               r_first;
    logic               w_first_next;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   w_len_next;
    logic [LEN_W-1:0]   w_len_inc;
    logic [CNT_W-1:0]   r_pkt_cnt;
    logic               r_err_trunc;

    logic               w_load;
    logic               w_push;
    out_beat_t          w_beat;
    logic               w_head_ack;
    logic               w_head_rd;
    logic               w_pload_ack;
    logic               w_pload_rd;
    logic               w_cnt_inc;
    logic               w_trunc;

    assign w_len_inc = r_len + LEN_W'(1);

    // Control state and per-packet bookkeeping.
    always_ff @(posedge I_sys_clk) begin
        if (I_sys_rst) begin
            r_state     <= IDLE;
            r_no_pload  <= 1'b0;
            r_first     <= 1'b0;
            r_len       <= '0;
            r_pkt_cnt   <= '0;
            r_err_trunc <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_no_pload  <= w_no_pload_next;
            r_first     <= w_first_next;
            r_len       <= w_len_next;
            r_err_trunc <= w_trunc;
            if (w_cnt_inc) begin
                r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
            end
        end
    end

    // Next state, FIFO grants/pops and the beat offered to the output register.
    // Reads only happen when the output register can take the byte in the same
    // cycle, except in FLUSH where the discarded tail is drained regardless.
    always_comb begin
        w_state_next    = r_state;
        w_no_pload_next = r_no_pload;
        w_first_next    = r_first;
        w_len_next      = r_len;
        w_head_ack      = 1'b0;
        w_head_rd       = 1'b0;
        w_pload_ack     = 1'b0;
        w_pload_rd      = 1'b0;
        w_push          = 1'b0;
        w_beat          = '0;
        w_cnt_inc       = 1'b0;
        w_trunc         = 1'b0;

        case (r_state)
            IDLE: begin
                if (I_enable && I_fifo_head_req) begin
                    w_no_pload_next = I_head_no_pload;
                    w_state_next    = H_ACK;
                end
            end
            H_ACK: begin
                w_head_ack   = 1'b1;
                w_first_next = 1'b1;
                w_state_next = H_RD;
            end
            H_RD: begin
                if (!I_fifo_head_empty && w_load) begin
                    w_head_rd    = 1'b1;
                    w_push       = 1'b1;
                    w_beat.data  = I_fifo_head_rdata[7:0];
                    w_beat.hdr   = 1'b1;
                    w_beat.sop   = r_first;
                    w_first_next = 1'b0;
                    if (I_fifo_head_rdata[LAST_BIT]) begin
                        if (r_no_pload) begin
                            w_beat.eop   = 1'b1;
                            w_cnt_inc    = 1'b1;
                            w_state_next = IDLE;
                        end else begin
                            w_state_next = P_WAIT;
                        end
                    end
                end
            end
            P_WAIT: begin
                if (I_fifo_pload_req) begin
                    w_state_next = P_ACK;
                end
            end
            P_ACK: begin
                w_pload_ack  = 1'b1;
                w_len_next   = '0;
                w_state_next = P_RD;
            end
            P_RD: begin
                if (!I_fifo_pload_empty && w_load) begin
                    w_pload_rd  = 1'b1;
                    w_push      = 1'b1;
                    w_beat.data = I_fifo_pload_rdata[7:0];
                    w_len_next  = w_len_inc;
                    if (I_fifo_pload_rdata[LAST_BIT]) begin
                        w_beat.eop   = 1'b1;
                        w_cnt_inc    = 1'b1;
                        w_state_next = IDLE;
                    end else if (w_len_inc == MAX_LEN) begin
                        w_beat.eop   = 1'b1;
                        w_cnt_inc    = 1'b1;
                        w_trunc      = 1'b1;
                        w_state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (!I_fifo_pload_empty) begin
                    w_pload_rd = 1'b1;
                    if (I_fifo_pload_rdata[LAST_BIT]) begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    lzw_fwd_out_reg u_out_reg (
        .i_clk  (I_sys_clk),
        .i_rst  (I_sys_rst),
        .i_push (w_push),
        .i_beat (w_beat),
        .o_load (w_load),
        .lzw    (lzw)
    );

    assign O_fifo_head_ack  = w_head_ack;
    assign O_fifo_head_rd   = w_head_rd;
    assign O_fifo_pload_ack = w_pload_ack;
    assign O_fifo_pload_rd  = w_pload_rd;
    assign O_pkt_cnt        = r_pkt_cnt;
    assign O_err_trunc      = r_err_trunc;
    assign O_busy           = (r_state != IDLE) || lzw.lzw_valid;

endmodule
